// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver, LSB first, mid-bit sampling, bit period CLK_DIV+1 clk cycles.
// Ports: clk (clock), rst (sync active-high reset), rx (serial line, idle high),
//        data (last correctly framed byte), valid (1-cycle pulse, data updated),
//        frame_err (1-cycle pulse, stop bit low), busy (high in START/DATA/STOP).
// Option: define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer (+2 cycles latency).
module uart_rx_byte #(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;
    localparam logic [7:0] HALF = 8'(CLK_DIV / 2);
    localparam logic [7:0] FULL = 8'(CLK_DIV);
    state_t     state;
    logic [7:0] cnt;
    logic [7:0] sh;
    logic [2:0] idx;
    logic       rx_s;
    logic       sync_ok;
`ifdef UART_RX_SYNC_EN
    logic       s1, s2;
    logic [1:0] fill;
    // The synchronizer resets to 1, so its first two outputs after reset are
    // not the line; WAIT_HIGH ignores them until fill shows the pipe holds real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            fill <= 2'b00;
        end else begin
            s1   <= rx;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
        end
    end
    assign rx_s    = s2;
    assign sync_ok = fill[1];
`else
    assign rx_s    = rx;
    assign sync_ok = 1'b1;
`endif
    assign busy = (state == START) || (state == DATA) || (state == STOP);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_HIGH;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= 8'h00;
            sh        <= 8'h00;
            idx       <= 3'd0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                WAIT_HIGH: if (rx_s && sync_ok) state <= IDLE;
                IDLE: if (!rx_s) begin
                    cnt   <= HALF;
                    state <= START;
                end
                default: if (cnt != 8'h00) begin
                    cnt <= cnt - 8'h01;
                end else begin
                    cnt <= FULL;
                    case (state)
                        START: begin
                            state <= rx_s ? IDLE : DATA;
                            idx   <= 3'd0;
                        end
                        DATA: begin
                            sh  <= {rx_s, sh[7:1]};
                            idx <= idx + 3'd1;
                            if (idx == 3'd7) state <= STOP;
                        end
                        STOP: begin
                            // Back to IDLE at mid-stop-bit so a following start edge is never missed.
                            if (rx_s) begin
                                data  <= sh;
                                valid <= 1'b1;
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
                            end
                        end
                        default: state <= WAIT_HIGH;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed self-checking bench for uart_rx_byte with CLK_DIV=8.
module tb_uart_rx_byte;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 89;
`else
    localparam int LAT = 87;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;
    int cmp = 0, bad = 0;
    int cyc = 0, e_cyc = 0, v_cyc = 0, f_cyc = 0;
    int nv = 0, nf = 0, nboth = 0;
    bit busy_seen = 0;
    uart_rx_byte #(.CLK_DIV(8)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (valid) begin nv++; v_cyc = cyc; end
        if (frame_err) begin nf++; f_cyc = cyc; end
        if (valid && frame_err) nboth++;
        if (busy) busy_seen = 1;
    end
    // Called at a negedge; each bit is held for 9 clock cycles. The start edge
    // is seen by the DUT at the next rising edge, recorded as e_cyc.
    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        e_cyc = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (9) @(negedge clk);
        end
    endtask
    task automatic test_reset;
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        cmp++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", data); end
        cmp++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid); end
        cmp++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask
    task automatic test_single;
        int v0, f0;
        v0 = nv; f0 = nf; busy_seen = 0;
        send(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        cmp++; if (data !== 8'hA5) begin bad++; $display("FAIL a5_data got %h want a5", data); end
        cmp++; if (nv !== v0 + 1) begin bad++; $display("FAIL a5_valid_cycles got %0d want %0d", nv - v0, 1); end
        cmp++; if (v_cyc + 1 - e_cyc !== LAT) begin bad++; $display("FAIL a5_latency got E+%0d want E+%0d", v_cyc + 1 - e_cyc, LAT); end
        cmp++; if (nf !== f0) begin bad++; $display("FAIL a5_ferr got %0d want 0", nf - f0); end
        cmp++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL a5_busy_seen got %b want 1", busy_seen); end
        cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy_after got %b want 0", busy); end
    endtask
    task automatic test_back_to_back;
        int v0, f0;
        v0 = nv; f0 = nf;
        send(8'h00, 1'b1);
        cmp++; if (data !== 8'h00) begin bad++; $display("FAIL b2b_first got %h want 00", data); end
        send(8'hFF, 1'b1);
        repeat (3) @(negedge clk);
        cmp++; if (data !== 8'hFF) begin bad++; $display("FAIL b2b_second got %h want ff", data); end
        cmp++; if (nv !== v0 + 2) begin bad++; $display("FAIL b2b_valid_count got %0d want 2", nv - v0); end
        cmp++; if (nf !== f0) begin bad++; $display("FAIL b2b_ferr got %0d want 0", nf - f0); end
    endtask
    task automatic test_glitch;
        int v0, f0;
        v0 = nv; f0 = nf; busy_seen = 0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        cmp++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL glitch_start got %b want 1", busy_seen); end
        cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got %b want 0", busy); end
        cmp++; if (nv !== v0) begin bad++; $display("FAIL glitch_valid got %0d want 0", nv - v0); end
        cmp++; if (nf !== f0) begin bad++; $display("FAIL glitch_ferr got %0d want 0", nf - f0); end
        cmp++; if (data !== 8'hFF) begin bad++; $display("FAIL glitch_data got %h want ff", data); end
    endtask
    task automatic test_frame_err;
        int v0, f0;
        v0 = nv; f0 = nf;
        send(8'h3C, 1'b0);
        repeat (11) @(negedge clk);
        rx = 1'b1;
        cmp++; if (nf !== f0 + 1) begin bad++; $display("FAIL ferr_count got %0d want 1", nf - f0); end
        cmp++; if (f_cyc + 1 - e_cyc !== LAT) begin bad++; $display("FAIL ferr_latency got E+%0d want E+%0d", f_cyc + 1 - e_cyc, LAT); end
        cmp++; if (nv !== v0) begin bad++; $display("FAIL ferr_valid got %0d want 0", nv - v0); end
        cmp++; if (data !== 8'hFF) begin bad++; $display("FAIL ferr_data got %h want ff", data); end
        repeat (6) @(negedge clk);
        send(8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        cmp++; if (data !== 8'h5A) begin bad++; $display("FAIL ferr_next_data got %h want 5a", data); end
        cmp++; if (nv !== v0 + 1) begin bad++; $display("FAIL ferr_next_valid got %0d want 1", nv - v0); end
    endtask
    task automatic test_mid_reset;
        int v0, f0;
        logic [7:0] b;
        b = 8'h42;
        v0 = nv; f0 = nf;
        rx = 1'b0;
        repeat (9) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (9) @(negedge clk);
        end
        rx = b[4];
        repeat (4) @(negedge clk);
        cmp++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_before got %b want 1", busy); end
        rx = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busy_seen = 0;
        repeat (30) @(negedge clk);
        cmp++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL rst_low_line_start got %b want 0", busy_seen); end
        cmp++; if (nv !== v0) begin bad++; $display("FAIL rst_valid got %0d want 0", nv - v0); end
        cmp++; if (nf !== f0) begin bad++; $display("FAIL rst_ferr got %0d want 0", nf - f0); end
        cmp++; if (data !== 8'h00) begin bad++; $display("FAIL rst_data got %h want 00", data); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h81, 1'b1);
        repeat (3) @(negedge clk);
        cmp++; if (data !== 8'h81) begin bad++; $display("FAIL rst_next_data got %h want 81", data); end
        cmp++; if (nv !== v0 + 1) begin bad++; $display("FAIL rst_next_valid got %0d want 1", nv - v0); end
    endtask
    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_mid_reset;
        cmp++; if (nboth !== 0) begin bad++; $display("FAIL pulse_overlap got %0d want 0", nboth); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
